lcd_region_arbiter: RTL

- Shares the single LCD 8080 write path between N_REQ independent display-region producers (e.g. price panel, status banner, full-frame image).
- Grants one requester at a time, round-robin. For the granted rectangle it emits the column-address (0x2A), page-address (0x2B) and memory-write (0x2C) command words, then forwards that requester's pixel stream.
- Sits between the producers and the LCD bus-timing engine, which consumes a word stream (wr_valid/wr_ready/wr_dcx/wr_data) and generates CSX/WRX/DCX.
- Arbitration is enabled only after the panel init sequencer asserts lcd_ready.

---
 rtl/lcd_pkg.sv | 64 ++++++
 rtl/lcd_rr_picker.sv | 35 +++
 rtl/lcd_region_arbiter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants, state encoding and rectangle helpers for the
// LCD region arbiter.
//   LCD_CMD_*      8080 command words (column / page address, memory write)
//   lcd_state_e    arbiter state encoding
//   lcd_rect_t     latched inclusive rectangle bounds
package lcd_pkg;

  localparam int unsigned LCD_COORD_W  = 9;
  localparam int unsigned LCD_PIXCNT_W = 17;

  localparam logic [15:0] LCD_CMD_CASET = 16'h002A;
  localparam logic [15:0] LCD_CMD_PASET = 16'h002B;
  localparam logic [15:0] LCD_CMD_RAMWR = 16'h002C;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_CASET,
    ST_PASET,
    ST_RAMWR,
    ST_PIXELS,
    ST_FIN
  } lcd_state_e;

  typedef logic [LCD_COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x0;
    coord_t x1;
    coord_t y0;
    coord_t y1;
  } lcd_rect_t;

  // Rectangle is unusable if inverted or reaching past the panel edge.
  function automatic logic rect_bad(lcd_rect_t r, int unsigned w, int unsigned h);
    return (r.x0 > r.x1) || (r.y0 > r.y1) || (32'(r.x1) >= w) || (32'(r.y1) >= h);
  endfunction

  // Pixel count of a (valid) rectangle; a full 240x320 frame needs 17 bits.
  function automatic logic [LCD_PIXCNT_W-1:0] rect_area(lcd_rect_t r);
    logic [9:0] cols;
    logic [9:0] rows;
    cols = 10'(r.x1) - 10'(r.x0) + 10'd1;
    rows = 10'(r.y1) - 10'(r.y0) + 10'd1;
    return LCD_PIXCNT_W'(20'(cols) * 20'(rows));
  endfunction

  // Word idx of an address command: cmd, a[15:8], a[7:0], b[15:8], b[7:0].
  function automatic logic [15:0] addr_word(logic [2:0] idx, logic [15:0] cmd,
                                            coord_t a, coord_t b);
    logic [15:0] a16;
    logic [15:0] b16;
    a16 = 16'(a);
    b16 = 16'(b);
    case (idx)
      3'd0:    return cmd;
      3'd1:    return {8'h00, a16[15:8]};
      3'd2:    return {8'h00, a16[7:0]};
      3'd3:    return {8'h00, b16[15:8]};
      default: return {8'h00, b16[7:0]};
    endcase
  endfunction

endpackage

// File: rtl/lcd_rr_picker.sv
// lcd_rr_picker: combinational round-robin select.
//   req     per-requester level request
//   rr_ptr  index of the last served requester; search starts at rr_ptr+1
//   pick_c  one-hot winner (zero when no request)
//   any_c   at least one request pending
module lcd_rr_picker #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] pick_c,
  output logic             any_c
);

  logic        found;
  int unsigned idx;

  // First requester at or after rr_ptr+1, wrapping; rr_ptr itself is checked last.
  always_comb begin
    pick_c = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = (32'(rr_ptr) + k) % N_REQ;
      if (!found && req[IDX_W'(idx)]) begin
        pick_c[IDX_W'(idx)] = 1'b1;
        found               = 1'b1;
      end
    end
  end

  assign any_c = |req;

endmodule

// File: rtl/lcd_region_arbiter.sv
// lcd_region_arbiter: shares the LCD 8080 word path between N_REQ region
// producers. For each granted rectangle it emits CASET/PASET/RAMWR command
// words, then passes the owner's pixel stream straight through.
// Optional build macro: LCD_ARB_TIMEOUT_EN enables a pixel-stall watchdog.
//   sys_clk, sys_rst      clock, async active-high reset
//   lcd_ready             panel init done; gates new grants only
//   req, x0/x1/y0/y1      per-requester request and inclusive rectangle
//   pix_valid/data/ready  per-requester RGB565 pixel stream
//   grant, done, err      ownership, completion pulse, reject/abort pulse
//   wr_valid/ready/dcx/data  word stream to the bus-timing engine
module lcd_region_arbiter
  import lcd_pkg::*;
#(
  parameter int unsigned N_REQ       = 2,
  parameter int unsigned LCD_W       = 240,
  parameter int unsigned LCD_H       = 320,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst,
  input  logic                         lcd_ready,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ*LCD_COORD_W-1:0] x0,
  input  logic [N_REQ*LCD_COORD_W-1:0] x1,
  input  logic [N_REQ*LCD_COORD_W-1:0] y0,
  input  logic [N_REQ*LCD_COORD_W-1:0] y1,
  input  logic [N_REQ-1:0]             pix_valid,
  input  logic [N_REQ*16-1:0]          pix_data,
  output logic [N_REQ-1:0]             pix_ready,
  output logic [N_REQ-1:0]             grant,
  output logic [N_REQ-1:0]             done,
  output logic [N_REQ-1:0]             err,
  output logic                         wr_valid,
  input  logic                         wr_ready,
  output logic                         wr_dcx,
  output logic [15:0]                  wr_data
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned WD_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [IDX_W-1:0] RR_RST = IDX_W'(N_REQ - 1);
  localparam logic [WD_W-1:0]  WD_MAX = WD_W'(TIMEOUT_CYC - 1);

  lcd_state_e               state_q, state_d;
  logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]         gidx_q, gidx_d;
  logic [N_REQ-1:0]         grant_q, grant_d;
  logic [N_REQ-1:0]         done_q, done_d;
  logic [N_REQ-1:0]         err_q, err_d;
  lcd_rect_t                rect_q, rect_d;
  logic [LCD_PIXCNT_W-1:0]  pixcnt_q, pixcnt_d;
  logic [2:0]               word_idx_q, word_idx_d;
  logic                     cmd_valid_q, cmd_valid_d;
  logic                     cmd_dcx_q, cmd_dcx_d;
  logic [15:0]              cmd_data_q, cmd_data_d;

  lcd_rect_t                rect_a [N_REQ];
  logic [15:0]              pix_data_a [N_REQ];
  logic [N_REQ-1:0]         pick_c;
  logic                     any_c;
  logic [IDX_W-1:0]         pick_idx_c;
  lcd_rect_t                pick_rect_c;
  logic                     pix_valid_sel_c;
  logic [15:0]              pix_data_sel_c;
  logic                     in_pix_c;
  logic                     pix_hs_c;
  logic                     cmd_hs_c;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign rect_a[gi] = '{x0: x0[gi*LCD_COORD_W +: LCD_COORD_W],
                          x1: x1[gi*LCD_COORD_W +: LCD_COORD_W],
                          y0: y0[gi*LCD_COORD_W +: LCD_COORD_W],
                          y1: y1[gi*LCD_COORD_W +: LCD_COORD_W]};
    assign pix_data_a[gi] = pix_data[gi*16 +: 16];
  end

  lcd_rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .pick_c (pick_c),
    .any_c  (any_c)
  );

  // Winner's index and rectangle, plus the granted pixel stream.
  always_comb begin
    pick_idx_c      = '0;
    pick_rect_c     = '0;
    pix_valid_sel_c = 1'b0;
    pix_data_sel_c  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_c[i]) begin
        pick_idx_c  = IDX_W'(i);
        pick_rect_c = rect_a[i];
      end
      if (grant_q[i]) begin
        pix_valid_sel_c = pix_valid[i];
        pix_data_sel_c  = pix_data_a[i];
      end
    end
  end

  // Pixels bypass the command registers so the stream runs at full rate.
  assign in_pix_c  = (state_q == ST_PIXELS);
  assign pix_hs_c  = in_pix_c && pix_valid_sel_c && wr_ready;
  assign cmd_hs_c  = cmd_valid_q && wr_ready;
  assign wr_valid  = in_pix_c ? pix_valid_sel_c : cmd_valid_q;
  assign wr_dcx    = in_pix_c ? 1'b1 : cmd_dcx_q;
  assign wr_data   = in_pix_c ? pix_data_sel_c : cmd_data_q;
  assign pix_ready = (in_pix_c && wr_ready) ? grant_q : '0;
  assign grant     = grant_q;
  assign done      = done_q;
  assign err       = err_q;

`ifdef LCD_ARB_TIMEOUT_EN
  logic [WD_W-1:0] wd_q, wd_d;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) wd_q <= '0;
    else         wd_q <= wd_d;
  end
`else
  logic [WD_W-1:0] wd_unused;
  assign wd_unused = WD_MAX;
`endif

  // Next-state and command-word sequencing.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gidx_d      = gidx_q;
    grant_d     = grant_q;
    done_d      = '0;
    err_d       = '0;
    rect_d      = rect_q;
    pixcnt_d    = pixcnt_q;
    word_idx_d  = word_idx_q;
    cmd_valid_d = cmd_valid_q;
    cmd_dcx_d   = cmd_dcx_q;
    cmd_data_d  = cmd_data_q;
`ifdef LCD_ARB_TIMEOUT_EN
    wd_d        = in_pix_c ? wd_q : '0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (lcd_ready && any_c) begin
          grant_d = pick_c;
          gidx_d  = pick_idx_c;
          rect_d  = pick_rect_c;
          // err is registered, so decide it here to have it high during CHECK.
          err_d   = rect_bad(pick_rect_c, LCD_W, LCD_H) ? pick_c : '0;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (rect_bad(rect_q, LCD_W, LCD_H)) begin
          grant_d  = '0;
          rr_ptr_d = gidx_q;
          state_d  = ST_IDLE;
        end else begin
          pixcnt_d    = rect_area(rect_q);
          word_idx_d  = 3'd0;
          cmd_valid_d = 1'b1;
          cmd_dcx_d   = 1'b0;
          cmd_data_d  = LCD_CMD_CASET;
          state_d     = ST_CASET;
        end
      end
      ST_CASET: begin
        if (cmd_hs_c) begin
          if (word_idx_q == 3'd4) begin
            word_idx_d = 3'd0;
            cmd_dcx_d  = 1'b0;
            cmd_data_d = LCD_CMD_PASET;
            state_d    = ST_PASET;
          end else begin
            word_idx_d = word_idx_q + 3'd1;
            cmd_dcx_d  = 1'b1;
            cmd_data_d = addr_word(word_idx_q + 3'd1, LCD_CMD_CASET, rect_q.x0, rect_q.x1);
          end
        end
      end
      ST_PASET: begin
        if (cmd_hs_c) begin
          if (word_idx_q == 3'd4) begin
            word_idx_d = 3'd0;
            cmd_dcx_d  = 1'b0;
            cmd_data_d = LCD_CMD_RAMWR;
            state_d    = ST_RAMWR;
          end else begin
            word_idx_d = word_idx_q + 3'd1;
            cmd_dcx_d  = 1'b1;
            cmd_data_d = addr_word(word_idx_q + 3'd1, LCD_CMD_PASET, rect_q.y0, rect_q.y1);
          end
        end
      end
      ST_RAMWR: begin
        if (cmd_hs_c) begin
          cmd_valid_d = 1'b0;
          cmd_dcx_d   = 1'b0;
          cmd_data_d  = '0;
          state_d     = ST_PIXELS;
        end
      end
      ST_PIXELS: begin
        if (pix_hs_c) begin
          pixcnt_d = pixcnt_q - LCD_PIXCNT_W'(1);
          if (pixcnt_q == LCD_PIXCNT_W'(1)) begin
            done_d  = grant_q;
            state_d = ST_FIN;
          end
`ifdef LCD_ARB_TIMEOUT_EN
          wd_d = '0;
        end else if (!pix_valid_sel_c) begin
          // Abandon a stalled producer; the panel's next CASET ends the RAMWR.
          if (wd_q == WD_MAX) begin
            err_d    = grant_q;
            grant_d  = '0;
            rr_ptr_d = gidx_q;
            wd_d     = '0;
            state_d  = ST_IDLE;
          end else begin
            wd_d = wd_q + WD_W'(1);
          end
`endif
        end
      end
      ST_FIN: begin
        grant_d  = '0;
        rr_ptr_d = gidx_q;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= RR_RST;
      gidx_q      <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      err_q       <= '0;
      rect_q      <= '0;
      pixcnt_q    <= '0;
      word_idx_q  <= '0;
      cmd_valid_q <= 1'b0;
      cmd_dcx_q   <= 1'b0;
      cmd_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gidx_q      <= gidx_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rect_q      <= rect_d;
      pixcnt_q    <= pixcnt_d;
      word_idx_q  <= word_idx_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_dcx_q   <= cmd_dcx_d;
      cmd_data_q  <= cmd_data_d;
    end
  end

endmodule
